// File: rtl/seq_det_pkg.sv
// Shared types and constants for the sequence-detector scheduler.
package seq_det_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      WAIT   = 3'd2,
      STEP   = 3'd3,
      REPORT = 3'd4
   } state_t;

   localparam int TICK_DIV_BOARD = 50_000_000;
   localparam int TICK_DIV_SIM   = 4;

endpackage

// File: rtl/seq_det_sched_tick.sv
// tick_gen: enable-gated modulo-TICK_DIV counter with terminal-count pulse
// and synchronous restart.
module tick_gen #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic restart,
   output logic tc
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (restart) begin
         count <= '0;
      end else if (en) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

   assign tc = en && (count == LAST);

endmodule

// File: rtl/seq_det_sched.sv
// Single-clock scheduler that feeds a serial sequence detector one bit per tick
// and counts its Mealy hits. Optional hit map: define SEQ_DET_SCHED_HITMAP_EN.
module seq_det_sched
   import seq_det_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int TICK_DIV = TICK_DIV_BOARD,
   parameter int CNT_W    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              det_bit,
   output logic              det_en,
   output logic              det_clr,
   input  logic              det_hit,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CNT_W-1:0]  res_count,
`ifdef SEQ_DET_SCHED_HITMAP_EN
   output logic [DATA_W-1:0] res_map,
`endif
   output logic              busy,
   output logic [2:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising clk edge where valid and ready
   // are both high; valid never waits for ready, and ready is a pure state decode.

   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IW-1:0]    LAST_IDX = IW'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t            state, state_nxt;
   logic [DATA_W-1:0] word;
   logic [IW-1:0]     idx;
   logic [CNT_W-1:0]  count;
   logic              tick_tc;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .reset   (reset),
      .en      (state == WAIT),
      .restart (state != WAIT),
      .tc      (tick_tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = CLEAR;
         CLEAR:   state_nxt = WAIT;
         WAIT:    if (tick_tc) state_nxt = STEP;
         STEP:    state_nxt = (idx == LAST_IDX) ? REPORT : WAIT;
         REPORT:  if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign det_clr   = (state == CLEAR);
   assign det_en    = (state == STEP);
   assign res_valid = (state == REPORT);
   assign res_count = count;
   assign dbg_state = state;

   // The word is shifted left as bits go out, so det_bit always loads the MSB.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word    <= '0;
         idx     <= '0;
         count   <= '0;
         det_bit <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  word  <= in_data;
                  idx   <= '0;
                  count <= '0;
               end
            end
            CLEAR: begin
               det_bit <= word[DATA_W-1];
               word    <= {word[DATA_W-2:0], 1'b0};
            end
            STEP: begin
               if (det_hit && (count != CNT_MAX)) count <= count + 1'b1;
               if (idx != LAST_IDX) begin
                  idx     <= idx + 1'b1;
                  det_bit <= word[DATA_W-1];
                  word    <= {word[DATA_W-2:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SEQ_DET_SCHED_HITMAP_EN
   // Hits shift in from the LSB, so the first step lands on bit DATA_W-1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_map <= '0;
      end else if (state == IDLE && in_valid) begin
         res_map <= '0;
      end else if (state == STEP) begin
         res_map <= {res_map[DATA_W-2:0], det_hit};
      end
   end
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: two instances (CNT_W=4 and CNT_W=1) with detector models.
module tb_seq_det_sched;
   import seq_det_pkg::*;

   localparam int DW = 8;
   localparam int TD = TICK_DIV_SIM;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic          in_valid, res_ready;
   logic [DW-1:0] in_data;
   logic          in_ready0, det_bit0, det_en0, det_clr0, hit0, res_valid0, busy0;
   logic          in_ready1, det_bit1, det_en1, det_clr1, hit1, res_valid1, busy1;
   logic [3:0]    res_count0;
   logic [0:0]    res_count1;
   logic [2:0]    st0, st1;
`ifdef SEQ_DET_SCHED_HITMAP_EN
   logic [DW-1:0] map0, map1;
   logic [DW-1:0] expm_q[$];
`endif

   logic [3:0] exp0_q[$];
   logic [0:0] exp1_q[$];

   seq_det_sched #(.DATA_W(DW), .TICK_DIV(TD), .CNT_W(4)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .det_bit(det_bit0), .det_en(det_en0), .det_clr(det_clr0),
      .det_hit(hit0), .res_valid(res_valid0), .res_ready(res_ready),
      .res_count(res_count0),
`ifdef SEQ_DET_SCHED_HITMAP_EN
      .res_map(map0),
`endif
      .busy(busy0), .dbg_state(st0)
   );

   seq_det_sched #(.DATA_W(DW), .TICK_DIV(TD), .CNT_W(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .det_bit(det_bit1), .det_en(det_en1), .det_clr(det_clr1),
      .det_hit(hit1), .res_valid(res_valid1), .res_ready(res_ready),
      .res_count(res_count1),
`ifdef SEQ_DET_SCHED_HITMAP_EN
      .res_map(map1),
`endif
      .busy(busy1), .dbg_state(st1)
   );

   // Detector model: start(0) -0-> S1(1) -0-> S2(2), S2 holds on 0, any 1 -> start.
   logic [1:0] ds0, ds1;
   always @(posedge clk or negedge reset) begin
      if (!reset) ds0 <= 2'd0;
      else if (det_clr0) ds0 <= 2'd0;
      else if (det_en0) ds0 <= det_bit0 ? 2'd0 : ((ds0 == 2'd2) ? 2'd2 : ds0 + 2'd1);
   end
   always @(posedge clk or negedge reset) begin
      if (!reset) ds1 <= 2'd0;
      else if (det_clr1) ds1 <= 2'd0;
      else if (det_en1) ds1 <= det_bit1 ? 2'd0 : ((ds1 == 2'd2) ? 2'd2 : ds1 + 2'd1);
   end
   assign hit0 = (ds0 == 2'd2) && det_bit0;
   assign hit1 = (ds1 == 2'd2) && det_bit1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int exp_hits(input logic [DW-1:0] w, output logic [DW-1:0] m);
      int s = 0;
      int h = 0;
      m = '0;
      for (int i = DW - 1; i >= 0; i--) begin
         if (w[i]) begin
            if (s == 2) begin
               h++;
               m[i] = 1'b1;
            end
            s = 0;
         end else if (s < 2) begin
            s++;
         end
      end
      return h;
   endfunction

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Monitor: timing of strobes per word, latency, and scoreboard pops.
   int acc_cyc = 0, last_en = 0, en_cnt = 0, clr_cnt = 0;
   logic rv_prev = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         if (in_valid && in_ready0) begin
            acc_cyc = cyc;
            en_cnt  = 0;
            clr_cnt = 0;
         end
         if (det_en0 || det_clr0) chk("en_clr_excl", 32'(det_en0 & det_clr0), 0);
         if (det_clr0) clr_cnt++;
         if (det_en0) begin
            if (en_cnt > 0) chk("en_gap", cyc - last_en, TD + 1);
            last_en = cyc;
            en_cnt++;
         end
         if (res_valid0 && !rv_prev) begin
            chk("latency", cyc - acc_cyc - 1, 1 + DW * (TD + 1));
            chk("en_pulses", en_cnt, DW);
            chk("clr_pulses", clr_cnt, 1);
         end
         rv_prev = res_valid0;
         if (res_valid0 && res_ready) begin
            if (exp0_q.size() == 0) chk("res0_unexpected", 1, 0);
            else chk("res_count_w4", 32'(res_count0), 32'(exp0_q.pop_front()));
`ifdef SEQ_DET_SCHED_HITMAP_EN
            if (expm_q.size() == 0) chk("map_unexpected", 1, 0);
            else chk("res_map", 32'(map0), 32'(expm_q.pop_front()));
`endif
         end
         if (res_valid1 && res_ready) begin
            if (exp1_q.size() == 0) chk("res1_unexpected", 1, 0);
            else chk("res_count_w1", 32'(res_count1), 32'(exp1_q.pop_front()));
         end
      end else begin
         rv_prev = 1'b0;
      end
   end

   task automatic send_word(input logic [DW-1:0] w);
      int n = 0;
      int h;
      logic [DW-1:0] m;
      @(negedge clk);
      while (!in_ready0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      h = exp_hits(w, m);
      exp0_q.push_back(4'(h > 15 ? 15 : h));
      exp1_q.push_back(1'(h > 1 ? 1 : h));
`ifdef SEQ_DET_SCHED_HITMAP_EN
      expm_q.push_back(m);
`endif
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) chk("done_timeout", 0, 1);
      @(negedge clk);
      chk("idle_after", 32'(busy0), 0);
   endtask

   task automatic check_reset_outs(input string tag);
      chk(tag, {det_bit0, det_en0, det_clr0, res_valid0, res_count0, busy0, st0}, 0);
      chk({tag, "_ready"}, 32'(in_ready0), 1);
`ifdef SEQ_DET_SCHED_HITMAP_EN
      chk({tag, "_map"}, 32'(map0), 0);
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outs("rst_held");
      reset = 1'b1;
      @(negedge clk);
      check_reset_outs("rst_released");

      send_word(8'h24);
      wait_done();
      send_word(8'hFF);
      wait_done();
      send_word(8'h00);
      wait_done();
      for (int i = 0; i < 4; i++) begin
         send_word(DW'($urandom_range(0, 255)));
         wait_done();
      end

      // Stalled result: output must hold and new words must be refused.
      res_ready = 1'b0;
      send_word(8'h24);
      n = 0;
      while (!res_valid0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("stall_reach_report", 32'(res_valid0), 1);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_data  = 8'hFF;
         end
         @(negedge clk);
         chk("stall_valid", 32'(res_valid0), 1);
         chk("stall_count", 32'(res_count0), 2);
         chk("stall_in_ready", 32'(in_ready0), 0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      res_ready = 1'b1;
      wait_done();
      repeat (3) @(negedge clk);
      chk("no_second_accept", 32'(busy0), 0);

      // Abort during the wait before bit 3, then a clean word.
      send_word(8'h24);
      n = 0;
      while (n < 3) begin
         @(negedge clk);
         if (det_en0) n++;
         if (cyc > acc_cyc + 200) break;
      end
      chk("abort_reached_bit3", n, 3);
      @(negedge clk);
      chk("abort_in_wait", 32'(st0), 32'(WAIT));
      #2;
      reset = 1'b0;
      #1;
      chk("abort_busy0", 32'(busy0), 0);
      chk("abort_busy1", 32'(busy1), 0);
      chk("abort_state", 32'(st0), 32'(IDLE));
      exp0_q.delete();
      exp1_q.delete();
`ifdef SEQ_DET_SCHED_HITMAP_EN
      expm_q.delete();
`endif
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      send_word(8'h24);
      wait_done();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
